// File: rtl/pulse_sync_arb.sv
// Round-robin arbiter sharing one clksrc->clkdest pulse-synchronizer channel
// between N_REQ single-cycle event sources, with handshake timeout and guard gap.
module pulse_sync_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned GUARD_CYC = 8
) (
  input  logic             clksrc,
  input  logic             rstb_clksrc,
  input  logic [N_REQ-1:0] req_pulse_i,
  input  logic             ovf_clr_i,
  input  logic             sync_done_i,
  output logic             sync_pulse_o,
  output logic [ID_W-1:0]  sync_id_o,
  output logic [N_REQ-1:0] req_pending_o,
  output logic [N_REQ-1:0] req_overflow_o,
  output logic             timeout_err_o,
  output logic             busy_o
);

  localparam int unsigned CNT_MAX = (TIMEOUT > GUARD_CYC) ? TIMEOUT : GUARD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GUARD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    sync_id_q, sync_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   overflow_q, overflow_d;
  logic               sync_pulse_q, timeout_err_q, busy_q;
  logic               timeout_c;
  logic               grant_valid_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic [N_REQ-1:0]   clr_vec_c;
  logic [N_REQ-1:0]   ovf_set_c;

  // Round-robin search starting just above the last granted requester.
  always_comb begin
    int unsigned idx;
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    idx           = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % N_REQ;
      if (!grant_valid_c && pending_q[ID_W'(idx)]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = ID_W'(idx);
      end
    end
  end

  // Pending/overflow bookkeeping; a new event on the clearing cycle re-arms the bit.
  always_comb begin
    clr_vec_c  = '0;
    if (state_q == ST_ISSUE) clr_vec_c = N_REQ'(1) << sync_id_q;
    ovf_set_c  = req_pulse_i & pending_q & ~clr_vec_c;
    pending_d  = (pending_q & ~clr_vec_c) | req_pulse_i;
    overflow_d = ovf_clr_i ? ovf_set_c : (overflow_q | ovf_set_c);
  end

  // Next-state logic; the wait counter starts at zero in ISSUE so the
  // timeout pulse lands exactly TIMEOUT cycles after sync_pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sync_id_d    = sync_id_q;
    last_grant_d = last_grant_q;
    timeout_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c) begin
          sync_id_d    = grant_idx_c;
          last_grant_d = grant_idx_c;
          cnt_d        = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sync_done_i) begin
          cnt_d   = CNT_W'(GUARD_CYC - 1);
          state_d = ST_GUARD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          cnt_d     = CNT_W'(GUARD_CYC - 1);
          state_d   = ST_GUARD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clksrc or negedge rstb_clksrc) begin
    if (!rstb_clksrc) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sync_id_q     <= '0;
      last_grant_q  <= ID_W'(N_REQ - 1);
      pending_q     <= '0;
      overflow_q    <= '0;
      sync_pulse_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_id_q     <= sync_id_d;
      last_grant_q  <= last_grant_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      sync_pulse_q  <= (state_d == ST_ISSUE);
      timeout_err_q <= timeout_c;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign sync_pulse_o   = sync_pulse_q;
  assign sync_id_o      = sync_id_q;
  assign req_pending_o  = pending_q;
  assign req_overflow_o = overflow_q;
  assign timeout_err_o  = timeout_err_q;
  assign busy_o         = busy_q;

endmodule
